// File: rtl/seg_scan_if.sv
// rtl/seg_scan_if.sv - producer-to-scanner input handshake (data, blank mask, valid/ready)
interface seg_scan_if;
    logic [31:0] in_data;
    logic [7:0]  in_blank;
    logic        in_valid;
    logic        in_ready;

    modport master (output in_data, output in_blank, output in_valid, input in_ready);
    modport slave  (input in_data, input in_blank, input in_valid, output in_ready);
endinterface

// File: rtl/seg_scan.sv
// rtl/seg_scan.sv - eight-digit multiplexed 7-segment scanner with tear-free one-entry update buffer
module seg_scan #(
    parameter int DIV = 100000
) (
    input  logic       CLK100MHZ,
    input  logic       CPU_RESETN,
    seg_scan_if.slave  s,
    output logic [3:0] nibble,
    output logic [7:0] en,
    output logic       frame_done
);
    localparam int            CW   = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [31:0]   active_data;
    logic [7:0]    active_blank;
    logic [31:0]   pend_data;
    logic [7:0]    pend_blank;
    logic          pend_flag;

    logic          tick;
    logic          wrap;
    logic          load;
    logic          accept;
    logic [2:0]    idx_next;
    logic [31:0]   data_next;
    logic [7:0]    blank_next;

    assign tick       = (cnt == LAST);
    assign wrap       = tick && (idx == 3'd7);
    // Pending data only moves to the display at a frame boundary so a frame never mixes two values.
    assign load       = wrap && pend_flag;
    assign accept     = s.in_valid && !pend_flag;
    assign s.in_ready = !pend_flag;

    // Next-state views let the outputs register in step with idx and show freshly loaded data on the wrap edge.
    assign idx_next   = tick ? idx + 3'd1 : idx;
    assign data_next  = load ? pend_data  : active_data;
    assign blank_next = load ? pend_blank : active_blank;

    // Slot counter and digit index.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            cnt <= '0;
            idx <= 3'd0;
        end else begin
            cnt <= tick ? '0 : cnt + CW'(1);
            idx <= idx_next;
        end
    end

    // One-entry holding buffer; load and accept are exclusive because accept needs an empty buffer.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            pend_flag  <= 1'b0;
            pend_data  <= 32'h0;
            pend_blank <= 8'h00;
        end else if (load) begin
            pend_flag  <= 1'b0;
        end else if (accept) begin
            pend_flag  <= 1'b1;
            pend_data  <= s.in_data;
            pend_blank <= s.in_blank;
        end
    end

    // Displayed value, replaced only at the wrap.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            active_data  <= 32'h0;
            active_blank <= 8'hFE;
        end else begin
            active_data  <= data_next;
            active_blank <= blank_next;
        end
    end

    // Registered digit value, active-low anode enable and frame pulse.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            nibble     <= 4'h0;
            en         <= 8'hFE;
            frame_done <= 1'b0;
        end else begin
            nibble     <= data_next[{idx_next, 2'b00} +: 4];
            en         <= blank_next[idx_next] ? 8'hFF : ~(8'b1 << idx_next);
            frame_done <= wrap;
        end
    end
endmodule

// File: tb/tb_seg_scan.sv
// tb/tb_seg_scan.sv - self-checking bench for seg_scan
module tb_seg_scan;
    localparam int DIV   = 4;
    localparam int FRAME = 8 * DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] nibble;
    logic [7:0] en;
    logic       frame_done;

    seg_scan_if bus();

    seg_scan #(.DIV(DIV)) dut (
        .CLK100MHZ  (clk),
        .CPU_RESETN (rst_n),
        .s          (bus.slave),
        .nibble     (nibble),
        .en         (en),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: c = rising edges since reset release, displayed value, pending queue (depth 1).
    int          c;
    logic [31:0] m_data;
    logic [7:0]  m_blank;
    logic [31:0] q_data[$];
    logic [7:0]  q_blank[$];
    int          fd_first;

    typedef struct {
        logic [3:0] exp_nibble;
        logic [7:0] exp_en;
    } slot_vec_t;
    slot_vec_t scan_tab[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at c=%0d: got %h expected %h", name, c, act, exp);
        end
    endtask

    task automatic model_reset();
        c       = 0;
        m_data  = 32'h0;
        m_blank = 8'hFE;
        q_data.delete();
        q_blank.delete();
        fd_first = -1;
    endtask

    task automatic check_all();
        int          d;
        logic [7:0]  exp_en;
        logic [3:0]  exp_nib;
        d       = (c / DIV) % 8;
        exp_nib = 4'((m_data >> (4 * d)) & 32'hF);
        exp_en  = m_blank[d] ? 8'hFF : 8'((~(32'h1 << d)) & 32'hFF);
        chk("nibble", 32'(nibble), 32'(exp_nib));
        chk("en", 32'(en), 32'(exp_en));
        chk("frame_done", 32'(frame_done), 32'((c > 0) && (c % FRAME == 0)));
        chk("in_ready", 32'(bus.in_ready), 32'(q_data.size() == 0));
        if (frame_done && fd_first < 0) fd_first = c;
    endtask

    // Called at a negedge: check outputs, drive inputs, advance one clock, update model, return at the next negedge.
    task automatic cycle(input logic v, input logic [31:0] d, input logic [7:0] b);
        bit acc;
        check_all();
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_blank = b;
        acc = v && (q_data.size() == 0);
        @(posedge clk);
        #1;
        if (((c + 1) % FRAME == 0) && q_data.size() > 0) begin
            m_data  = q_data.pop_front();
            m_blank = q_blank.pop_front();
        end
        if (acc) begin
            q_data.push_back(d);
            q_blank.push_back(b);
        end
        c++;
        @(negedge clk);
    endtask

    task automatic idle_until(input int target);
        while (c < target) cycle(1'b0, 32'h0, 8'h00);
    endtask

    initial begin
        scan_tab[0] = '{4'hF, 8'hFE};
        scan_tab[1] = '{4'hE, 8'hFD};
        scan_tab[2] = '{4'hD, 8'hFB};
        scan_tab[3] = '{4'hC, 8'hF7};
        scan_tab[4] = '{4'hB, 8'hEF};
        scan_tab[5] = '{4'hA, 8'hDF};
        scan_tab[6] = '{4'h9, 8'hBF};
        scan_tab[7] = '{4'h8, 8'h7F};

        bus.in_valid = 1'b0;
        bus.in_data  = 32'h0;
        bus.in_blank = 8'h00;
        model_reset();

        // Reset state
        #12;
        chk("rst_en", 32'(en), 32'hFE);
        chk("rst_nibble", 32'(nibble), 32'h0);
        chk("rst_frame_done", 32'(frame_done), 32'h0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Idle after reset: digit 0 for DIV cycles, then blanked digits, first frame pulse 32 cycles in
        idle_until(DIV);
        chk("first_slot_en", 32'(en), 32'hFF);
        idle_until(40);
        chk("first_frame_done_cycle", 32'(fd_first), 32'(FRAME));

        // Load mid-frame then backpressure with a different value
        cycle(1'b1, 32'h89ABCDEF, 8'h00);
        chk("ready_after_accept", 32'(bus.in_ready), 32'h0);
        repeat (3) cycle(1'b1, 32'h11111111, 8'hFF);
        idle_until(2 * FRAME - 1);
        chk("ready_before_wrap", 32'(bus.in_ready), 32'h0);
        cycle(1'b0, 32'h0, 8'h00);
        chk("ready_after_wrap", 32'(bus.in_ready), 32'h1);

        // Table-driven frame scan of 89ABCDEF
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < DIV; j++) begin
                chk($sformatf("tab_nibble_%0d", k), 32'(nibble), 32'(scan_tab[k].exp_nibble));
                chk($sformatf("tab_en_%0d", k), 32'(en), 32'(scan_tab[k].exp_en));
                cycle(1'b0, 32'h0, 8'h00);
            end
        end

        // Transfer on the idx 7 tick cycle: current wrap keeps old value
        idle_until(4 * FRAME - 1);
        cycle(1'b1, 32'h7654321A, 8'h04);
        chk("simul_old_nibble", 32'(nibble), 32'hF);
        chk("simul_ready", 32'(bus.in_ready), 32'h0);
        idle_until(5 * FRAME);
        chk("simul_new_nibble", 32'(nibble), 32'hA);
        idle_until(5 * FRAME + DIV);
        chk("blank_d1_en", 32'(en), 32'hFD);
        chk("blank_d1_nibble", 32'(nibble), 32'h1);
        idle_until(5 * FRAME + 2 * DIV);
        chk("blank_d2_en", 32'(en), 32'hFF);
        idle_until(5 * FRAME + 3 * DIV);
        chk("blank_d3_en", 32'(en), 32'hF7);

        // Reset during digit 5 with data pending
        cycle(1'b1, 32'hDEADBEEF, 8'h00);
        idle_until(5 * FRAME + 5 * DIV + 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_en", 32'(en), 32'hFE);
        chk("midrst_nibble", 32'(nibble), 32'h0);
        chk("midrst_ready", 32'(bus.in_ready), 32'h1);
        chk("midrst_frame_done", 32'(frame_done), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        idle_until(FRAME + 8);
        chk("midrst_no_old_data", 32'(nibble), 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            cycle($urandom_range(0, 3) == 0, $urandom, 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 Parameter DIV, default 100000, clock cycles per digit slot (1 kHz digit rate at 100 MHz); legal range 2..2^20.
REQ-002 Port CLK100MHZ  input  1  system clock; all state changes on its rising edge.
REQ-003 Port CPU_RESETN  input  1  reset, asynchronous, active-low.
REQ-004 Port in_data  input  32  eight hex digits; digit k = in_data[4k+3:4k], digit 0 rightmost.
REQ-005 Port in_blank  input  8  per-digit blank mask; bit k = 1 blanks digit k.
REQ-006 Port in_valid  input  1  producer offers in_data/in_blank this cycle.
REQ-007 Port in_ready  output  1  block can accept a new value this cycle.
REQ-008 Port nibble  output  4  hex value of the currently scanned digit, fed to the 7-segment decoder.
REQ-009 Port en  output  8  anode enables, active-low, one-hot-low or all-high.
REQ-010 Port frame_done  output  1  one-cycle pulse when the scan wraps from digit 7 to digit 0.

Function
REQ-011 Slot counter: cnt counts 0..DIV-1 and wraps to 0; tick is asserted when cnt == DIV-1.
REQ-012 Digit index: idx (3 bits) increments on each tick, wrapping 7 -> 0; it holds between ticks.
REQ-013 Scan order is 0,1,2,...,7,0; each digit is displayed for exactly DIV cycles.
REQ-014 Registers: active_data (32 bits) and active_blank (8 bits) drive the display; pend_data, pend_blank and pend_flag form a one-entry holding buffer.
REQ-015 Handshake: in_ready = !pend_flag (combinational); a transfer occurs when in_valid && in_ready, capturing in_data/in_blank into the pending registers and setting pend_flag.
REQ-016 in_valid while in_ready is low is ignored; there is no overwrite of pending data.
REQ-017 Tear-free update: on a tick with idx == 7 and pend_flag = 1, active_* load from pend_* and pend_flag clears; in_ready rises the next cycle.
REQ-018 Simultaneous accept and wrap tick in the same cycle: the new value goes to pending and is applied at the following wrap, not the current one.
REQ-019 Outputs are registered and update on the same edge as idx.
- nibble = active_data[4*idx+3 : 4*idx].
- en = 8'hFF if active_blank[idx] = 1, else all-high except bit idx low.
REQ-020 On the wrap edge the displayed digit-0 value comes from the newly loaded active_* when REQ-017 applies.
REQ-021 frame_done is high for exactly the one cycle following each 7 -> 0 idx transition.
REQ-022 No latch or combinational path exists from in_data or in_blank to nibble or en.

Reset
REQ-023 While CPU_RESETN = 0, state is forced asynchronously:
- cnt = 0, idx = 0, pend_flag = 0.
- active_data = 0, active_blank = 8'hFE.
- nibble = 4'h0, en = 8'hFE, frame_done = 0; in_ready is 1.
REQ-024 Reset asserted mid-scan or with data pending discards the pending data and restarts the scan at digit 0 with the count at 0.
REQ-025 After CPU_RESETN deasserts, the first tick occurs DIV cycles later.

Verification (DIV = 4)
REQ-026 Reset check: reset released, in_valid low -> en = FE, nibble = 0 for 4 cycles, then en = FF (digits 1-7 blanked); frame_done first pulses 32 cycles after release.
REQ-027 Load and scan: accept in_data = 32'h89ABCDEF, in_blank = 00 mid-frame -> in_ready low until the wrap; the next frame shows nibble F,E,D,C,B,A,9,8 with en FE,FD,FB,F7,EF,DF,BF,7F, 4 cycles each.
REQ-028 Backpressure: second in_valid while pend_flag = 1 with data 32'h11111111 -> ignored; the first pending value is displayed; in_ready stays 0 until the wrap.
REQ-029 Simultaneous event: transfer presented on the idx = 7 tick cycle -> the current wrap keeps the old value; the new value appears one full frame (32 cycles) later.
REQ-030 Blanking: in_blank = 8'b0000_0100 -> en = FF during digit-2 slot; other digits are normal.
REQ-031 Reset mid-operation: CPU_RESETN pulsed low during idx = 5 with data pending -> immediate en = FE, nibble = 0, in_ready = 1; the old pending value is never displayed.
